fabric_warmboot_ctrl: RTL and testbench
=======================================

Name: fabric_warmboot_ctrl

Overview:
Sequences a warm reconfiguration of the eFPGA fabric. On a boot request raised by the fabric's WARMBOOT primitive, it fetches the selected bitstream slot from an external word-addressed memory. It then streams that slot, one word at a time, into the fabric configuration loader's bitstream input. It holds the WARMBOOT reset while loading, and reports completion, or an error, once the loader finishes.

Parameters:
ADDR_WIDTH, 20, memory word-address width
SLOT_SHIFT, 16, slot base address = slot << SLOT_SHIFT; must be less than ADDR_WIDTH
MAX_WORDS, 65535, largest legal payload length in words, excluding the header
DRAIN_TIMEOUT, 1024, maximum cycles to wait for the loader to report configured after the last word

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
warmboot_boot_i  in  1  boot request from fabric, level; acted on at rising edge
warmboot_slot_i  in  4  slot number, sampled on the boot rising edge
warmboot_reset_o  out  1  WARMBOOT reset to fabric, high while a load is in progress
mem_rd_o  out  1  one-cycle read strobe
mem_addr_o  out  ADDR_WIDTH  read address, valid when mem_rd_o is high
mem_rvalid_i  in  1  read data valid, at least 1 cycle after mem_rd_o
mem_rdata_i  in  32  read data
bitstream_data_o  out  32  word to the configuration loader
bitstream_valid_o  out  1  one-cycle qualifier per word
cfg_busy_i  in  1  loader busy
cfg_configured_i  in  1  loader reports fabric configured
busy_o  out  1  controller not IDLE
done_o  out  1  one-cycle pulse on successful completion
error_o  out  1  sticky error flag; cleared by the next accepted boot

Behaviour:
- Reset: async assertion forces state IDLE and clears every output, counter and register to 0, mid-transfer included. No further mem_rd_o or bitstream_valid_o is issued after reset.
- Edge detect: boot_q is registered. start = warmboot_boot_i & ~boot_q & (state == IDLE). Rising edges outside IDLE are ignored and are not queued.
- States:
  - IDLE:
    - on start: latch slot; addr = slot << SLOT_SHIFT; clear error_o; go to HDR_RD.
  - HDR_RD:
    - assert mem_rd_o for 1 cycle at addr; go to HDR_WAIT.
  - HDR_WAIT:
    - on mem_rvalid_i: len = mem_rdata_i.
    - len == 0 or len > MAX_WORDS: set error_o, go to IDLE.
    - otherwise: remaining = len; addr += 1; go to DAT_RD.
  - DAT_RD:
    - mem_rd_o pulse at addr; go to DAT_WAIT.
  - DAT_WAIT:
    - on mem_rvalid_i: register the word. bitstream_data_o = word and bitstream_valid_o = 1 in the next cycle, for exactly 1 cycle.
    - remaining -= 1; addr += 1.
    - remaining then 0: go to DRAIN; otherwise go to DAT_RD.
  - DRAIN:
    - timer counts up from 0.
    - cfg_configured_i == 1 and cfg_busy_i == 0: done_o pulse, go to IDLE.
    - timer reaches DRAIN_TIMEOUT - 1 first: set error_o, go to IDLE.
    - configured and timeout on the same cycle: success wins.
- Reads: at most one read is outstanding. mem_rvalid_i outside HDR_WAIT and DAT_WAIT is ignored.
- warmboot_reset_o and busy_o: both high in every state except IDLE, asserted the cycle after start. warmboot_reset_o falls in the same cycle busy_o falls.
- Address arithmetic: modulo 2^ADDR_WIDTH; wrap is permitted and is not flagged.
- Counters: the remaining counter is 17 bits and the timer is clog2(DRAIN_TIMEOUT)+1 bits.
- Throughput: minimum 3 cycles per payload word (rd, wait, rvalid); memory latency adds to this.
- Status outputs: done_o and error_o are never both asserted. error_o holds until the next accepted start.

Test Plan:
- Slot 2, header 3, payload A,B,C, memory latency 1; loader asserts configured 5 cycles after the last word -> reads at 0x20000, 0x20001, 0x20002, 0x20003; bitstream_valid_o pulses with A, B, C in order; done_o pulses once; warmboot_reset_o and busy_o drop together.
- Header 0 in slot 1 -> exactly one read at 0x10000; no bitstream_valid_o; error_o = 1; return to IDLE. A new boot edge clears error_o.
- Header 5, loader never configures, DRAIN_TIMEOUT = 16 -> 5 words streamed; error_o set 16 cycles into DRAIN; done_o never asserted.
- Boot toggled 0→1→0→1 during the DAT states -> only the first edge acts; one header read total; the slot stays as first latched.
- rst_ni asserted during DAT_WAIT with a read pending, then a late mem_rvalid_i -> all outputs 0 immediately; the late rvalid produces no bitstream_valid_o.
- Memory latency 4 and header MAX_WORDS+1 -> error after the header read. With a MAX_WORDS header -> all words streamed with a 6-cycle spacing.

Source files
------------

// File: rtl/fabric_warmboot_ctrl.sv
// Warm-boot sequencer: fetches a length-prefixed bitstream slot from word memory
// and streams it into the fabric configuration loader while holding the fabric in reset.
module fabric_warmboot_ctrl #(
    parameter int unsigned ADDR_WIDTH    = 20,
    parameter int unsigned SLOT_SHIFT    = 16,
    parameter int unsigned MAX_WORDS     = 65535,
    parameter int unsigned DRAIN_TIMEOUT = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  warmboot_boot_i,
    input  logic [3:0]            warmboot_slot_i,
    output logic                  warmboot_reset_o,
    output logic                  mem_rd_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i,
    output logic [31:0]           bitstream_data_o,
    output logic                  bitstream_valid_o,
    input  logic                  cfg_busy_i,
    input  logic                  cfg_configured_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int unsigned TIMER_W = $clog2(DRAIN_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        IDLE,
        HDR_RD,
        HDR_WAIT,
        DAT_RD,
        DAT_WAIT,
        DRAIN
    } state_t;

    state_t                state;
    logic                  boot_q;
    logic [ADDR_WIDTH-1:0] addr;
    logic [16:0]           remaining;
    logic [TIMER_W-1:0]    timer;
    logic                  start;
    logic                  hdr_bad;
    logic [ADDR_WIDTH-1:0] slot_base;

    assign start     = warmboot_boot_i & ~boot_q & (state == IDLE);
    assign hdr_bad   = (mem_rdata_i == 32'd0) || (mem_rdata_i > 32'(MAX_WORDS));
    assign slot_base = ADDR_WIDTH'(warmboot_slot_i) << SLOT_SHIFT;
    assign mem_addr_o = addr;

    // NOTE: every piece of state, including the data and address registers, is reset so
    // that an abort mid-transfer leaves nothing half-issued on the memory or loader side.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state             <= IDLE;
            boot_q            <= 1'b0;
            addr              <= '0;
            remaining         <= '0;
            timer             <= '0;
            mem_rd_o          <= 1'b0;
            bitstream_data_o  <= '0;
            bitstream_valid_o <= 1'b0;
            warmboot_reset_o  <= 1'b0;
            busy_o            <= 1'b0;
            done_o            <= 1'b0;
            error_o           <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch below reads pre-edge values.
            boot_q            <= warmboot_boot_i;
            mem_rd_o          <= 1'b0;
            bitstream_valid_o <= 1'b0;
            done_o            <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        addr             <= slot_base;
                        error_o          <= 1'b0;
                        busy_o           <= 1'b1;
                        warmboot_reset_o <= 1'b1;
                        state            <= HDR_RD;
                    end
                end

                HDR_RD: begin
                    mem_rd_o <= 1'b1;
                    state    <= HDR_WAIT;
                end

                HDR_WAIT: begin
                    if (mem_rvalid_i) begin
                        if (hdr_bad) begin
                            error_o          <= 1'b1;
                            busy_o           <= 1'b0;
                            warmboot_reset_o <= 1'b0;
                            state            <= IDLE;
                        end else begin
                            remaining <= mem_rdata_i[16:0];
                            addr      <= addr + ADDR_WIDTH'(1);
                            state     <= DAT_RD;
                        end
                    end
                end

                DAT_RD: begin
                    mem_rd_o <= 1'b1;
                    state    <= DAT_WAIT;
                end

                DAT_WAIT: begin
                    if (mem_rvalid_i) begin
                        bitstream_data_o  <= mem_rdata_i;
                        bitstream_valid_o <= 1'b1;
                        remaining         <= remaining - 17'd1;
                        addr              <= addr + ADDR_WIDTH'(1);
                        if (remaining == 17'd1) begin
                            timer <= '0;
                            state <= DRAIN;
                        end else begin
                            state <= DAT_RD;
                        end
                    end
                end

                DRAIN: begin
                    // Success is tested first so it wins over a coincident timeout.
                    if (cfg_configured_i && !cfg_busy_i) begin
                        done_o           <= 1'b1;
                        busy_o           <= 1'b0;
                        warmboot_reset_o <= 1'b0;
                        state            <= IDLE;
                    end else if (timer == TIMER_W'(DRAIN_TIMEOUT - 1)) begin
                        error_o          <= 1'b1;
                        busy_o           <= 1'b0;
                        warmboot_reset_o <= 1'b0;
                        state            <= IDLE;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end

                default: begin
                    busy_o           <= 1'b0;
                    warmboot_reset_o <= 1'b0;
                    state            <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fabric_warmboot_ctrl.sv
// Directed bench for fabric_warmboot_ctrl: memory responder with programmable latency,
// scoreboard queues for read addresses and streamed words, and timing checks.
module tb_fabric_warmboot_ctrl;

    localparam int unsigned AW = 20;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          warmboot_boot_i;
    logic [3:0]    warmboot_slot_i;
    logic          warmboot_reset_o;
    logic          mem_rd_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_rvalid_i;
    logic [31:0]   mem_rdata_i;
    logic [31:0]   bitstream_data_o;
    logic          bitstream_valid_o;
    logic          cfg_busy_i;
    logic          cfg_configured_i;
    logic          busy_o;
    logic          done_o;
    logic          error_o;

    fabric_warmboot_ctrl #(
        .ADDR_WIDTH   (AW),
        .SLOT_SHIFT   (16),
        .MAX_WORDS    (20),
        .DRAIN_TIMEOUT(16)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .warmboot_boot_i  (warmboot_boot_i),
        .warmboot_slot_i  (warmboot_slot_i),
        .warmboot_reset_o (warmboot_reset_o),
        .mem_rd_o         (mem_rd_o),
        .mem_addr_o       (mem_addr_o),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rdata_i      (mem_rdata_i),
        .bitstream_data_o (bitstream_data_o),
        .bitstream_valid_o(bitstream_valid_o),
        .cfg_busy_i       (cfg_busy_i),
        .cfg_configured_i (cfg_configured_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .error_o          (error_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [63:0] NONE = 64'hBAD0_0000_0000_0000;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          lat = 1;
    int          spacing_exp = 0;
    int          prev_valid = -1;
    int          last_valid = 0;
    int          err_rise = 0;
    int          done_cnt = 0;
    int          valid_cnt = 0;
    logic [31:0] mem [int unsigned];
    logic [63:0] exp_a [$];
    logic [63:0] exp_w [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: one outstanding read, response after lat cycles.
    initial begin
        int          cnt = 0;
        bit          pend = 0;
        int unsigned raddr = 0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(negedge clk_i);
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pend         = 0;
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = mem.exists(raddr) ? mem[raddr] : 32'd0;
                end
            end
            if (mem_rd_o) begin
                pend  = 1;
                cnt   = lat;
                raddr = int'(mem_addr_o);
            end
        end
    end

    // Output monitor and scoreboard.
    initial begin
        logic [63:0] e;
        logic        err_q = 1'b0;
        forever begin
            @(negedge clk_i);
            cyc++;
            check("busy_vs_wbreset", 64'(busy_o), 64'(warmboot_reset_o));
            check("done_and_error", 64'(done_o & error_o), 64'd0);
            if (mem_rd_o) begin
                e = (exp_a.size() > 0) ? exp_a.pop_front() : NONE;
                check("rd_addr", 64'(mem_addr_o), e);
            end
            if (bitstream_valid_o) begin
                e = (exp_w.size() > 0) ? exp_w.pop_front() : NONE;
                check("bs_word", 64'(bitstream_data_o), e);
                if (spacing_exp != 0 && prev_valid >= 0)
                    check("bs_spacing", 64'(cyc - prev_valid), 64'(spacing_exp));
                prev_valid = cyc;
                last_valid = cyc;
                valid_cnt++;
            end
            if (done_o) done_cnt++;
            if (error_o && !err_q) err_rise = cyc;
            err_q = error_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic setup(input int slot, input logic [31:0] hdr, input int nstream);
        int unsigned base = int'(slot) << 16;
        logic [31:0] w;
        mem[base] = hdr;
        exp_a.push_back(64'(base));
        for (int i = 0; i < nstream; i++) begin
            w = {8'(slot), 8'h5A, 16'(i)};
            mem[base + 1 + i] = w;
            exp_a.push_back(64'(base + 1 + i));
            exp_w.push_back(64'(w));
        end
    endtask

    task automatic boot(input int slot);
        @(negedge clk_i);
        prev_valid      = -1;
        warmboot_slot_i = 4'(slot);
        warmboot_boot_i = 1'b1;
        @(negedge clk_i);
        warmboot_boot_i = 1'b0;
    endtask

    // sel: 0 done_o, 1 error_o, 2 word queue drained, 4 bitstream_valid_o
    task automatic wait_cond(input int sel, input int budget, input string tag);
        bit hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk_i);
            case (sel)
                0:       hit = done_o;
                1:       hit = error_o;
                2:       hit = (exp_w.size() == 0);
                default: hit = bitstream_valid_o;
            endcase
        end
        if (!hit) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        int d0;
        int v0;
        rst_ni           = 1'b0;
        warmboot_boot_i  = 1'b0;
        warmboot_slot_i  = '0;
        cfg_busy_i       = 1'b0;
        cfg_configured_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset_ctl", {58'd0, mem_rd_o, bitstream_valid_o, done_o, error_o, busy_o, warmboot_reset_o}, 64'd0);
        check("reset_addr", 64'(mem_addr_o), 64'd0);
        rst_ni = 1'b1;

        // Slot 2, three words, latency 1, loader configures 5 cycles after the last word.
        lat = 1; spacing_exp = 3; d0 = done_cnt;
        setup(2, 32'd3, 3);
        boot(2);
        check("t1_busy_after_start", {62'd0, busy_o, warmboot_reset_o}, 64'd3);
        wait_cond(2, 60, "t1_words");
        repeat (5) @(negedge clk_i);
        cfg_configured_i = 1'b1;
        wait_cond(0, 10, "t1_done");
        check("t1_busy_drop", {62'd0, busy_o, warmboot_reset_o}, 64'd0);
        cfg_configured_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check("t1_done_once", 64'(done_cnt - d0), 64'd1);
        check("t1_reads_left", 64'(exp_a.size()), 64'd0);

        // Zero-length header in slot 1, then a fresh boot clears the error.
        v0 = valid_cnt;
        setup(1, 32'd0, 0);
        boot(1);
        wait_cond(1, 30, "t2_err");
        check("t2_err_idle", {62'd0, error_o, busy_o}, 64'd2);
        check("t2_no_words", 64'(valid_cnt - v0), 64'd0);
        check("t2_one_read", 64'(exp_a.size()), 64'd0);
        cfg_configured_i = 1'b1;
        setup(3, 32'd1, 1);
        boot(3);
        check("t2_err_cleared", 64'(error_o), 64'd0);
        wait_cond(0, 30, "t2_done");
        cfg_configured_i = 1'b0;

        // Loader never configures: error exactly 16 cycles into DRAIN.
        d0 = done_cnt;
        setup(4, 32'd5, 5);
        boot(4);
        wait_cond(1, 200, "t3_err");
        check("t3_words", 64'(exp_w.size()), 64'd0);
        check("t3_drain_len", 64'(err_rise - last_valid), 64'd16);
        check("t3_no_done", 64'(done_cnt - d0), 64'd0);

        // Extra boot edges during the data phase are ignored.
        lat = 3; spacing_exp = 5; cfg_configured_i = 1'b1;
        mem[32'h9_0000] = 32'd2;
        setup(5, 32'd4, 4);
        boot(5);
        repeat (10) @(negedge clk_i);
        warmboot_slot_i = 4'd9;
        warmboot_boot_i = 1'b1; @(negedge clk_i);
        warmboot_boot_i = 1'b0; @(negedge clk_i);
        warmboot_boot_i = 1'b1; @(negedge clk_i);
        warmboot_boot_i = 1'b0;
        wait_cond(0, 100, "t4_done");
        repeat (6) @(negedge clk_i);
        check("t4_reads_left", 64'(exp_a.size()), 64'd0);
        check("t4_words_left", 64'(exp_w.size()), 64'd0);

        // Reset during DAT_WAIT with a read pending; the late response must be dropped.
        lat = 4; spacing_exp = 6; cfg_configured_i = 1'b0;
        setup(6, 32'd3, 3);
        boot(6);
        wait_cond(4, 40, "t5_first_word");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        exp_a.delete();
        exp_w.delete();
        #1;
        check("t5_rst_ctl", {58'd0, mem_rd_o, bitstream_valid_o, done_o, error_o, busy_o, warmboot_reset_o}, 64'd0);
        check("t5_rst_data", {12'd0, mem_addr_o, bitstream_data_o}, 64'd0);
        v0 = valid_cnt;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (10) @(negedge clk_i);
        check("t5_late_rvalid", 64'(valid_cnt - v0), 64'd0);
        check("t5_idle", {62'd0, busy_o, error_o}, 64'd0);

        // Latency 4: oversize header errors, maximum header streams at 6-cycle spacing.
        cfg_configured_i = 1'b1;
        v0 = valid_cnt;
        setup(7, 32'd21, 0);
        boot(7);
        wait_cond(1, 30, "t6_err");
        check("t6_over_words", 64'(valid_cnt - v0), 64'd0);
        check("t6_over_reads", 64'(exp_a.size()), 64'd0);
        d0 = done_cnt;
        setup(8, 32'd20, 20);
        boot(8);
        wait_cond(0, 300, "t6_done");
        repeat (3) @(negedge clk_i);
        check("t6_max_words", 64'(valid_cnt - v0), 64'd20);
        check("t6_max_done", {63'd0, error_o}, 64'd0);
        check("t6_done_once", 64'(done_cnt - d0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
